ram_uart_streamer: RTL

Parametrised RAM-to-serial dump engine: on a start request, reads a programmable run of words from a synchronous single-port RAM and transmits each word as bytes over an integrated 8N1 UART transmitter. Next generation of the team's RAM readout path. Adds configurable word width, address width, RAM read latency, baud divisor and byte order, plus a start/busy/done handshake. Sits between the result RAM and the board UART pin.

---
 rtl/ram_uart_streamer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ram_uart_streamer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram_uart_streamer: dumps a run of RAM words as bytes over an 8N1 UART line.
// Rev 1.0
// ---------------------------------------------------------------------------
module ram_uart_streamer #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 6,
    parameter int RAM_LATENCY  = 1,
    parameter int CLKS_PER_BIT = 10416,
    parameter int MSB_FIRST    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [DATA_W-1:0] data_from_ram,
    output logic              read_enable_to_ram,
    output logic [ADDR_W-1:0] address_to_ram,
    output logic              uart_tx,
    output logic              busy,
    output logic              done
);

    localparam int BYTES  = DATA_W / 8;
    localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);

    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES - 1);
    localparam logic [1:0]        WAIT_LAST = 2'((RAM_LATENCY > 1) ? RAM_LATENCY - 2 : 0);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]   ONE_WORD  = {{ADDR_W{1'b0}}, 1'b1};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_LOAD   = 3'd3;
    localparam logic [2:0] S_SEND   = 3'd4;
    localparam logic [2:0] S_TXWAIT = 3'd5;
    localparam logic [2:0] S_FINISH = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [BIDX_W-1:0] bidx_q, bidx_d;
    logic [1:0]        wait_q, wait_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              adv_q, adv_d;

    logic              tx_send;
    logic              tx_ready;
    logic [7:0]        tx_byte;

    logic              tx_busy_q;
    logic              tx_line_q;
    logic [8:0]        tx_frame_q;
    logic [3:0]        tx_bit_q;
    logic [CNT_W-1:0]  tx_cnt_q;

    // The outgoing byte always sits at the same end of the word register, which shifts per byte.
    assign tx_byte  = (MSB_FIRST != 0) ? word_q[DATA_W-1 -: 8] : word_q[7:0];
    assign tx_ready = ~tx_busy_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        words_d = words_q;
        bidx_d  = bidx_q;
        wait_d  = wait_q;
        word_d  = word_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        adv_d   = 1'b0;
        tx_send = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d  = 1'b1;
                    words_d = word_count;
                    if (word_count == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        addr_d  = base_addr;
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                wait_d  = '0;
                state_d = (RAM_LATENCY > 1) ? S_WAIT : S_LOAD;
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = S_LOAD;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            S_LOAD: begin
                word_d  = data_from_ram;
                bidx_d  = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                tx_send = 1'b1;
                state_d = S_TXWAIT;
            end
            S_TXWAIT: begin
                // Moving to the next word costs one extra cycle to step the address.
                if (adv_q) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    words_d = words_q - ONE_WORD;
                    state_d = S_READ;
                end else if (tx_ready) begin
                    if (bidx_q != LAST_BYTE) begin
                        bidx_d  = bidx_q + BIDX_W'(1);
                        word_d  = (MSB_FIRST != 0) ? (word_q << 8) : (word_q >> 8);
                        state_d = S_SEND;
                    end else if (words_q != ONE_WORD) begin
                        adv_d = 1'b1;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            words_q <= '0;
            bidx_q  <= '0;
            wait_q  <= '0;
            word_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            adv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            bidx_q  <= bidx_d;
            wait_q  <= wait_d;
            word_q  <= word_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            adv_q   <= adv_d;
        end
    end

    // 8N1 transmitter: start bit driven on accept, then data LSB first, then stop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_busy_q  <= 1'b0;
            tx_line_q  <= 1'b1;
            tx_frame_q <= '1;
            tx_bit_q   <= '0;
            tx_cnt_q   <= '0;
        end else if (!tx_busy_q) begin
            if (tx_send) begin
                tx_busy_q  <= 1'b1;
                tx_line_q  <= 1'b0;
                tx_frame_q <= {1'b1, tx_byte};
                tx_bit_q   <= '0;
                tx_cnt_q   <= '0;
            end
        end else if (tx_cnt_q != BIT_LAST) begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
        end else begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 4'd9) begin
                tx_busy_q <= 1'b0;
                tx_line_q <= 1'b1;
            end else begin
                tx_line_q  <= tx_frame_q[0];
                tx_frame_q <= {1'b1, tx_frame_q[8:1]};
                tx_bit_q   <= tx_bit_q + 4'd1;
            end
        end
    end

    assign read_enable_to_ram = (state_q == S_READ);
    assign address_to_ram     = addr_q;
    assign uart_tx            = tx_line_q;
    assign busy               = busy_q;
    assign done               = done_q;

endmodule
`default_nettype wire
